nios_system_sysid_ext: RTL and testbench

Parametrised system-identification peripheral on the Nios system interconnect, successor to the fixed two-word sysid slave. Returns a build ID, build timestamp and capability word, plus a 64-bit prescaled uptime counter with coherent lo/hi snapshot and a bank of writable scratch registers. Sits on the control slave port as a 32-bit Avalon-MM slave with fixed read latency of one cycle.

---
 rtl/nios_system_sysid_pkg.sv | 26 ++
 rtl/nios_system_sysid_uptime.sv | 38 +++
 rtl/nios_system_sysid_ext.sv | 131 +++++++++++++
 tb/tb_nios_system_sysid_ext.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_system_sysid_pkg.sv
// Shared register map, CTRL bit positions and CAPS layout for the extended sysid slave.
package nios_system_sysid_pkg;

    localparam logic [31:0] OFF_ID        = 32'd0;
    localparam logic [31:0] OFF_TIMESTAMP = 32'd1;
    localparam logic [31:0] OFF_CAPS      = 32'd2;
    localparam logic [31:0] OFF_UPTIME_LO = 32'd3;
    localparam logic [31:0] OFF_UPTIME_HI = 32'd4;
    localparam logic [31:0] OFF_CTRL      = 32'd5;
    localparam logic [31:0] OFF_SCRATCH0  = 32'd6;

    localparam int unsigned CTRL_CLEAR  = 0;
    localparam int unsigned CTRL_FREEZE = 1;

    localparam int unsigned CAPS_REV_LSB  = 0;
    localparam int unsigned CAPS_NSCR_LSB = 8;

    function automatic logic [31:0] caps_word(input logic [7:0] rev, input logic [7:0] nscr);
        return (32'(nscr) << CAPS_NSCR_LSB) | (32'(rev) << CAPS_REV_LSB);
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/nios_system_sysid_uptime.sv
// Prescaled 64-bit free-running uptime counter with clear and freeze controls.
module nios_system_sysid_uptime #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        freeze,
    output logic [63:0] count
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] prescale_q;
    logic [63:0]   count_q;

    // clear outranks freeze, freeze outranks the tick
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescale_q <= '0;
            count_q    <= '0;
        end else if (clear) begin
            prescale_q <= '0;
            count_q    <= '0;
        end else if (!freeze) begin
            if (prescale_q == PS_LAST) begin
                prescale_q <= '0;
                count_q    <= count_q + 64'd1;
            end else begin
                prescale_q <= prescale_q + 1'b1;
            end
        end
    end

    assign count = count_q;

endmodule

// File: rtl/nios_system_sysid_ext.sv
// Extended system-ID Avalon-MM slave: ID/timestamp/caps, uptime with lo/hi snapshot,
// CTRL and byte-maskable scratch registers; fixed one-cycle read latency.
module nios_system_sysid_ext
    import nios_system_sysid_pkg::*;
#(
    parameter logic [31:0] ID_VALUE     = 32'h8888_8888,
    parameter logic [31:0] TIMESTAMP    = 32'd0,
    parameter logic [7:0]  HW_REV       = 8'd2,
    parameter int unsigned NUM_SCRATCH  = 4,
    parameter logic [31:0] SCRATCH_INIT = 32'h0,
    parameter int unsigned PRESCALE     = 1,
    parameter int unsigned ADDR_W       = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [3:0]        byteenable,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    localparam int unsigned NS_ALLOC = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;
    localparam logic [31:0] NS_WORD  = NUM_SCRATCH;
    localparam logic [31:0] CAPS     = caps_word(HW_REV, NS_WORD[7:0]);

    if (ADDR_W < 3 || ADDR_W > 31) begin : g_bad_addr_w
        $fatal(1, "ADDR_W must be in 3..31");
    end
    if (NUM_SCRATCH > (2 ** ADDR_W) - 6) begin : g_bad_num_scratch
        $fatal(1, "NUM_SCRATCH exceeds the address space");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $fatal(1, "PRESCALE must be at least 1");
    end

    logic [31:0] addr_w;
    logic [31:0] scr_off;
    logic        is_scr;
    logic        ctrl_wr;
    logic        ctrl_clear;
    logic        ctrl_freeze;
    logic [63:0] uptime;
    logic [31:0] shadow;
    logic [31:0] rd_mux;
    logic [31:0] scratch [NS_ALLOC];

    assign addr_w  = 32'(address);
    assign scr_off = addr_w - OFF_SCRATCH0;
    assign is_scr  = (addr_w >= OFF_SCRATCH0) && (addr_w < OFF_SCRATCH0 + NUM_SCRATCH);

    // CTRL bits live in byte lane 0, so that lane gates the whole register
    assign ctrl_wr    = write && (addr_w == OFF_CTRL) && byteenable[0];
    assign ctrl_clear = ctrl_wr && writedata[CTRL_CLEAR];

    nios_system_sysid_uptime #(
        .PRESCALE (PRESCALE)
    ) u_uptime (
        .clock  (clock),
        .reset  (reset),
        .clear  (ctrl_clear),
        .freeze (ctrl_freeze),
        .count  (uptime)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl_freeze <= 1'b0;
        end else if (ctrl_wr) begin
            ctrl_freeze <= writedata[CTRL_FREEZE];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NS_ALLOC; i++) begin
                scratch[i] <= SCRATCH_INIT;
            end
        end else if (write && is_scr) begin
            for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
                if (scr_off == i) begin
                    scratch[i] <= (scratch[i] & ~lane_mask(byteenable))
                                | (writedata & lane_mask(byteenable));
                end
            end
        end
    end

    // hi half captured from the same pre-edge count the lo read returns
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow <= '0;
        end else if (read && (addr_w == OFF_UPTIME_LO)) begin
            shadow <= uptime[63:32];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr_w)
            OFF_ID:        rd_mux = ID_VALUE;
            OFF_TIMESTAMP: rd_mux = TIMESTAMP;
            OFF_CAPS:      rd_mux = CAPS;
            OFF_UPTIME_LO: rd_mux = uptime[31:0];
            OFF_UPTIME_HI: rd_mux = shadow;
            OFF_CTRL:      rd_mux[CTRL_FREEZE] = ctrl_freeze;
            default: begin
                for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
                    if (is_scr && (scr_off == i)) begin
                        rd_mux = scratch[i];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= read;
            if (read) begin
                readdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_nios_system_sysid_ext.sv
// Directed plus randomized bench for nios_system_sysid_ext against a cycle-level register model.
module tb_nios_system_sysid_ext;

    localparam logic [31:0] IDV   = 32'h1234_5678;
    localparam logic [31:0] TSV   = 32'h5F5E_1000;
    localparam int unsigned P     = 3;
    localparam int unsigned NS    = 4;
    localparam logic [31:0] SINIT = 32'h0;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;

    int checks   = 0;
    int failures = 0;

    // model state: counter value = base_m + floor(edges_m / P), unless forced
    logic        freeze_m;
    logic [31:0] scr_m [NS];
    logic [31:0] shadow_m;
    logic [63:0] base_m;
    int unsigned edges_m;
    bit          forced_m;
    logic [63:0] fval_m;

    nios_system_sysid_ext #(
        .ID_VALUE     (IDV),
        .TIMESTAMP    (TSV),
        .HW_REV       (8'd2),
        .NUM_SCRATCH  (NS),
        .SCRATCH_INIT (SINIT),
        .PRESCALE     (P),
        .ADDR_W       (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .byteenable    (byteenable),
        .writedata     (writedata),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] m_count();
        return forced_m ? fval_m : base_m + 64'(edges_m / P);
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a);
        logic [63:0] c = m_count();
        case (a)
            4'd0: return IDV;
            4'd1: return TSV;
            4'd2: return 32'h0000_0402;
            4'd3: return c[31:0];
            4'd4: return shadow_m;
            4'd5: return {30'd0, freeze_m, 1'b0};
            4'd6, 4'd7, 4'd8, 4'd9: return scr_m[a - 4'd6];
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        freeze_m = 1'b0;
        for (int i = 0; i < NS; i++) scr_m[i] = SINIT;
        shadow_m = '0;
        base_m   = '0;
        edges_m  = 0;
        forced_m = 0;
    endtask

    task automatic model_edge();
        logic [63:0] c = m_count();
        logic [31:0] m;
        bit clr;
        if (read && address == 4'd3) shadow_m = c[63:32];
        clr = write && address == 4'd5 && byteenable[0] && writedata[0];
        if (clr) begin
            base_m  = '0;
            edges_m = 0;
        end else if (!freeze_m) begin
            edges_m++;
        end
        if (write) begin
            if (address == 4'd5 && byteenable[0]) freeze_m = writedata[1];
            if (address >= 4'd6 && address <= 4'd9) begin
                m = {{8{byteenable[3]}}, {8{byteenable[2]}}, {8{byteenable[1]}}, {8{byteenable[0]}}};
                scr_m[address - 4'd6] = (scr_m[address - 4'd6] & ~m) | (writedata & m);
            end
        end
    endtask

    // one clock: inputs are stable at the posedge, outputs sampled at the next negedge
    task automatic cycle(input string tag);
        logic        exp_v;
        logic [31:0] exp_d;
        @(posedge clock);
        exp_v = read;
        exp_d = read ? m_read(address) : 32'd0;
        model_edge();
        @(negedge clock);
        check({tag, "_rvalid"}, {31'd0, readdatavalid}, {31'd0, exp_v});
        if (exp_v) check(tag, readdata, exp_d);
    endtask

    task automatic idle(input int n);
        read  = 1'b0;
        write = 1'b0;
        repeat (n) cycle("idle");
    endtask

    task automatic rd(input logic [3:0] a, input string tag);
        read    = 1'b1;
        write   = 1'b0;
        address = a;
        cycle(tag);
        read    = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        read       = 1'b0;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        byteenable = be;
        cycle("wr");
        write      = 1'b0;
    endtask

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0;
        address = '0; byteenable = '0; writedata = '0;
        model_reset();
        repeat (2) @(negedge clock);
        check("reset_rvalid", {31'd0, readdatavalid}, 32'd0);
        check("reset_rdata", readdata, 32'd0);
        reset = 1'b0;

        // back-to-back reads, then scratch lane masking, RO and unmapped
        read = 1'b1;
        address = 4'd0; cycle("rd_id");
        address = 4'd1; cycle("rd_ts");
        address = 4'd2; cycle("rd_caps");
        address = 4'd6; cycle("rd_scr0_init");
        read = 1'b0;
        wr(4'd6, 32'hDEAD_BEEF, 4'b0101);
        rd(4'd6, "rd_scr0_masked");
        check("scr0_masked_const", readdata, 32'h00AD_00EF);
        wr(4'd0, 32'hFFFF_FFFF, 4'hF);
        rd(4'd0, "rd_id_after_wr");
        rd(4'd15, "rd_unmapped");

        // uptime: free run, freeze, clear
        idle(30);
        rd(4'd3, "up_run");
        wr(4'd5, 32'h2, 4'hF);
        rd(4'd3, "up_frz_a");
        idle(20);
        rd(4'd3, "up_frz_b");
        rd(4'd5, "ctrl_frz");
        wr(4'd5, 32'h1, 4'hF);
        rd(4'd3, "up_clear");
        check("up_clear_const", readdata, 32'd0);
        rd(4'd5, "ctrl_after_clear");

        // clear written on the very edge the prescaler wraps
        for (int k = 0; k < P && (edges_m % P) != P - 1; k++) idle(1);
        wr(4'd5, 32'h1, 4'hF);
        rd(4'd3, "up_clear_tick");

        // snapshot coherency across the 32-bit boundary
        wr(4'd5, 32'h2, 4'hF);
        force dut.u_uptime.count_q = 64'h0000_0001_FFFF_FFFF;
        forced_m = 1; fval_m = 64'h0000_0001_FFFF_FFFF;
        rd(4'd3, "snap_lo");
        force dut.u_uptime.count_q = 64'h0000_0002_0000_0000;
        fval_m = 64'h0000_0002_0000_0000;
        rd(4'd4, "snap_hi_shadow");
        check("snap_hi_const", readdata, 32'd1);
        rd(4'd3, "snap_lo2");
        rd(4'd4, "snap_hi2");

        // 64-bit wrap
        force dut.u_uptime.count_q = 64'hFFFF_FFFF_FFFF_FFFF;
        fval_m = 64'hFFFF_FFFF_FFFF_FFFF;
        idle(1);
        release dut.u_uptime.count_q;
        base_m = fval_m - 64'(edges_m / P);
        forced_m = 0;
        wr(4'd5, 32'h0, 4'hF);
        idle(P + 1);
        rd(4'd3, "wrap_lo");
        rd(4'd4, "wrap_hi");

        // read and write together: read sees the pre-write value
        read = 1'b1; write = 1'b1; address = 4'd7;
        writedata = 32'hA5A5_5A5A; byteenable = 4'hF;
        cycle("rw_same");
        read = 1'b0; write = 1'b0;
        rd(4'd7, "rw_after");

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            address    = 4'($urandom_range(0, 15));
            read       = 1'($urandom % 2);
            write      = ($urandom % 4) == 0;
            byteenable = 4'($urandom);
            writedata  = $urandom;
            cycle("rand");
        end
        read = 1'b0; write = 1'b0;
        idle(1);

        // reset landing while a read response is pending
        read = 1'b1; address = 4'd0;
        @(posedge clock);
        #1 reset = 1'b1;
        read = 1'b0;
        @(negedge clock);
        check("rst_mid_rvalid", {31'd0, readdatavalid}, 32'd0);
        @(negedge clock);
        check("rst_mid_rvalid2", {31'd0, readdatavalid}, 32'd0);
        check("rst_mid_rdata", readdata, 32'd0);
        reset = 1'b0;
        model_reset();
        idle(1);
        rd(4'd6, "post_rst_scr");
        rd(4'd0, "post_rst_id");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
